video_timing_measure: RTL

Receive-side counterpart of the video timing generator. It watches a pixel-enabled raster (hbl, vbl, hsync, vsync) and measures line length, frame height, active area and sync positions. It regenerates active-area-aligned pixel and line counters and reports lock once the raster is stable. It sits downstream of any timing source, for example in front of the scaler/OSD path or on the debug status bus.

---
 rtl/video_timing_measure.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/video_timing_measure.sv
// Raster measurement: line/frame sizes, active area, sync positions and a lock FSM.
// Optional sync-position capture is enabled by defining VIDEO_MEASURE_SYNC_EN.
module video_timing_measure (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_pix,
  input  logic       hbl,
  input  logic       vbl,
  input  logic       hsync,
  input  logic       vsync,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output logic [8:0] h_last,
  output logic [8:0] h_active,
  output logic [8:0] v_last,
  output logic [8:0] v_active,
  output logic [8:0] hs_start,
  output logic [8:0] vs_start,
  output logic       frame_start,
  output logic       locked,
  output logic [1:0] lock_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARM    = 2'd1,
    CHECK  = 2'd2,
    LOCK   = 2'd3
  } lock_t;

  lock_t       state;
  lock_t       state_next;
  logic        chk_bad;
  logic        chk_bad_next;
  logic [8:0]  ref_h;
  logic [8:0]  ref_v;

  logic        hbl_q;
  logic        vbl_line_q;
  logic [9:0]  line_cnt;
  logic [9:0]  act_cnt;
  logic [8:0]  vact_cnt;

  logic        line_edge;
  logic        frame_edge;
  logic        timeout;
  logic [8:0]  h_len;
  logic [8:0]  act_len;
  logic [8:0]  hc_next;
  logic [8:0]  vc_line;
  logic [8:0]  vc_upd;
  logic        h_ok;
  logic        v_ok;

  // Edges are judged against the previous enabled sample; vbl only at line edges.
  assign line_edge  = clk_pix & ~hbl & hbl_q;
  assign frame_edge = line_edge & ~vbl & vbl_line_q;
  assign timeout    = clk_pix & (line_cnt == 10'd1023);
  assign h_len      = (line_cnt > 10'd511) ? 9'd511 : line_cnt[8:0];
  assign act_len    = (act_cnt > 10'd511) ? 9'd511 : act_cnt[8:0];
  assign hc_next    = line_edge ? 9'd0 : ((hc == 9'd511) ? hc : hc + 9'd1);
  assign vc_line    = frame_edge ? 9'd0 : ((vc == 9'd511) ? vc : vc + 9'd1);
  assign vc_upd     = line_edge ? vc_line : vc;
  assign h_ok       = (h_len == ref_h);
  assign v_ok       = (vc == ref_v);

  always_ff @(posedge clk) begin
    if (reset) begin
      hbl_q       <= 1'b0;
      vbl_line_q  <= 1'b0;
      line_cnt    <= 10'd0;
      act_cnt     <= 10'd0;
      vact_cnt    <= 9'd0;
      hc          <= 9'd0;
      vc          <= 9'd0;
      h_last      <= 9'd0;
      h_active    <= 9'd0;
      v_last      <= 9'd0;
      v_active    <= 9'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (clk_pix) begin
        hbl_q <= hbl;
        hc    <= hc_next;
        if (line_edge) begin
          line_cnt   <= 10'd0;
          act_cnt    <= 10'd0;
          h_last     <= h_len;
          h_active   <= act_len;
          vbl_line_q <= vbl;
          vc         <= vc_line;
          if (frame_edge) begin
            v_last      <= vc;
            v_active    <= vact_cnt;
            vact_cnt    <= 9'd0;
            frame_start <= 1'b1;
          end else if (!vbl_line_q && vact_cnt != 9'd511) begin
            vact_cnt <= vact_cnt + 9'd1;
          end
        end else begin
          if (line_cnt != 10'd1023) line_cnt <= line_cnt + 10'd1;
          // Counting the previous sample makes the falling-edge pixel itself count.
          if (!hbl_q && act_cnt != 10'd1023) act_cnt <= act_cnt + 10'd1;
        end
      end
    end
  end

`ifdef VIDEO_MEASURE_SYNC_EN
  logic hsync_q;
  logic vsync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hs_start <= 9'd0;
      vs_start <= 9'd0;
    end else if (clk_pix) begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      if (hsync && !hsync_q) hs_start <= hc_next;
      if (vsync && !vsync_q) vs_start <= vc_upd;
    end
  end
`else
  logic unused_sync;
  assign unused_sync = hsync ^ vsync ^ (|vc_upd);
  assign hs_start    = 9'd0;
  assign vs_start    = 9'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEARCH;
      chk_bad <= 1'b0;
      ref_h   <= 9'd0;
      ref_v   <= 9'd0;
    end else begin
      state   <= state_next;
      chk_bad <= chk_bad_next;
      if (state == ARM && frame_edge) begin
        ref_h <= h_len;
        ref_v <= vc;
      end
    end
  end

  always_comb begin
    state_next   = state;
    chk_bad_next = chk_bad;
    case (state)
      SEARCH: if (frame_edge) state_next = ARM;
      ARM: begin
        if (frame_edge) begin
          state_next   = CHECK;
          chk_bad_next = 1'b0;
        end
      end
      CHECK: begin
        if (frame_edge)
          state_next = (v_ok && h_ok && !chk_bad) ? LOCK : SEARCH;
        else if (line_edge && !h_ok)
          chk_bad_next = 1'b1;
      end
      LOCK: begin
        if ((line_edge && !h_ok) || (frame_edge && !v_ok)) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
    if (timeout) state_next = SEARCH;
  end

  always_comb begin
    locked     = (state == LOCK);
    lock_state = state;
  end

endmodule
